inst_block_memory: RTL and testbench
====================================

# inst_block_memory

Block-granular instruction memory sitting directly below the instruction cache. It serves 128-bit (four-word) block reads over the cache's READ/ADDRESS/BUSYWAIT handshake after a configurable latency. A word-wide load port preloads the program image before or during execution.

## Interface
- LATENCY, 5: BUSY cycles per read, ≥1.
- ADDR_W, 6: block address width; array depth 2^ADDR_W blocks.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INST_MEM_READ  in  1  block read request; held high by the cache until it samples BUSYWAIT low.
- INST_MEM_ADDRESS  in  ADDR_W  block index.
- INST_MEM_DATA  out  128  block data; word 0 in [127:96], word 1 in [95:64], word 2 in [63:32], word 3 in [31:0].
- INST_MEM_BUSYWAIT  out  1  combinational stall to the cache.
- LOAD_EN  in  1  word write strobe.
- LOAD_ADDR  in  ADDR_W+2  word index: upper ADDR_W bits select the block, lower 2 bits select the word.
- LOAD_DATA  in  32  word to write.

## Operation
- FSM states: IDLE, BUSY, RESPOND.
- IDLE with READ=1 at an edge:
  - latch INST_MEM_ADDRESS;
  - cnt ← LATENCY-1;
  - go to BUSY.
- IDLE with READ=0: stay in IDLE.
- BUSY with READ=0: abort to IDLE. No data update.
- BUSY with cnt≠0: cnt ← cnt-1.
- BUSY with cnt=0: INST_MEM_DATA ← array[latched addr]; go to RESPOND.
- RESPOND: always returns to IDLE after exactly one cycle, regardless of READ.
- INST_MEM_BUSYWAIT = (IDLE && READ) || BUSY.
  - BUSYWAIT rises in the same cycle READ rises. This is required because the cache checks BUSYWAIT one edge after raising READ.
  - BUSYWAIT is 0 in RESPOND.
- INST_MEM_DATA holds its last response until the next RESPOND entry.
- Address changes during BUSY are ignored; the latched address is used.
- Load port: when LOAD_EN=1 at an edge, array[LOAD_ADDR[ADDR_W+1:2]] word LOAD_ADDR[1:0] ← LOAD_DATA, using the lane mapping above. Writes are accepted in any state.
- Load and capture at the same edge on the same block: the captured data is the pre-write value.
- Load during BUSY to the target block, at an earlier edge than the capture: the new value is returned.
- Reset (RESET=0, asynchronous):
  - state ← IDLE, cnt ← 0, INST_MEM_DATA ← 0;
  - array contents are unaffected;
  - BUSYWAIT then follows READ combinationally;
  - reset mid-BUSY aborts the read with no RESPOND.
- After RESET deasserts with READ already high, the request is accepted at the first rising edge.

## Timing
- Request edges: READ rises after edge t0; accepted at t1; BUSY during t1..t1+LATENCY.
- RESPOND is entered at edge t1+LATENCY, with data registered at that edge.
- The cache samples BUSYWAIT=0 and the data at edge t1+LATENCY+1, then drops READ.
- Read latency, acceptance to data valid: LATENCY cycles. Back-to-back throughput: one block per LATENCY+2 cycles.
- cnt width is $clog2(LATENCY) with a minimum of 1. With LATENCY=1, BUSY lasts exactly one cycle.
- INST_MEM_DATA is registered (glitch-free). BUSYWAIT is combinational from state and READ.
- Load write visibility: a word written at edge t is readable by any capture at edge t+1 or later.

## Structure
- Shared package inst_mem_pkg holds:
  - BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4;
  - the state encoding typedef (IDLE/BUSY/RESPOND);
  - a function mapping word index to bit lane (127-32·w).
- Sub-module inst_mem_array holds the storage: 2^ADDR_W×128 registers, a 32-bit word write port, and an asynchronous 128-bit block read port.
- The top level contains only the FSM, the counter and the output register.

## Test plan
- Load block 3 with 0x11111111, 0x22222222, 0x33333333, 0x44444444 (word 0..3), LATENCY=5; READ with ADDRESS=3. Required response:
  - BUSYWAIT high from the READ cycle for 6 edges;
  - DATA=0x11111111_22222222_33333333_44444444 when BUSYWAIT falls;
  - RESPOND lasts exactly 1 cycle.
- Back-to-back reads of blocks 3 then 4 with READ dropped for one cycle between them: each is served independently; the second DATA matches block 4; no stale BUSYWAIT low in IDLE.
- Drop READ at the 2nd BUSY cycle: return to IDLE on the next edge; DATA unchanged from the previous value; no RESPOND.
- Write block 3 word 3 to 0xDEADBEEF:
  - at the same edge as the capture: DATA[31:0]=0x44444444;
  - two edges before the capture: DATA[31:0]=0xDEADBEEF.
- Assert RESET low mid-BUSY, release with READ=1:
  - DATA=0 immediately (asynchronous);
  - the read restarts at the first edge;
  - array contents intact (block 3 returns the loaded value).
- LATENCY=1: accept, then one BUSY cycle, then RESPOND; data valid 1 cycle after acceptance.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the block-granular instruction memory.
package inst_mem_pkg;

   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned WORDS_PER_BLOCK = 4;
   localparam int unsigned WORD_SEL_W      = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned LANE_W          = $clog2(BLOCK_W);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } state_e;

   // Word 0 occupies the top lane of a block, word 3 the bottom lane.
   function automatic logic [LANE_W-1:0] word_msb(input logic [WORD_SEL_W-1:0] w);
      return LANE_W'(BLOCK_W - 1 - WORD_W * 32'(w));
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Block storage: word-granular write port, asynchronous full-block read port.
module inst_mem_array
   import inst_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic                CLK,
   input  logic                WRITE_EN,
   input  logic [ADDR_W+1:0]   WRITE_ADDR,
   input  logic [WORD_W-1:0]   WRITE_DATA,
   input  logic [ADDR_W-1:0]   READ_ADDR,
   output logic [BLOCK_W-1:0]  READ_DATA
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [BLOCK_W-1:0] mem [DEPTH];

   // Contents survive reset so a preloaded program image is kept.
   always_ff @(posedge CLK) begin
      if (WRITE_EN) begin
         mem[WRITE_ADDR[ADDR_W+1:WORD_SEL_W]][word_msb(WRITE_ADDR[WORD_SEL_W-1:0]) -: WORD_W] <= WRITE_DATA;
      end
   end

   assign READ_DATA = mem[READ_ADDR];

endmodule

// File: rtl/inst_block_memory.sv
// Instruction memory below the I-cache: serves one 128-bit block per read
// request after LATENCY busy cycles, with a word-wide preload port.
module inst_block_memory
   import inst_mem_pkg::*;
#(
   parameter int unsigned LATENCY = 5,
   parameter int unsigned ADDR_W  = 6
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                INST_MEM_READ,
   input  logic [ADDR_W-1:0]   INST_MEM_ADDRESS,
   output logic [BLOCK_W-1:0]  INST_MEM_DATA,
   output logic                INST_MEM_BUSYWAIT,
   input  logic                LOAD_EN,
   input  logic [ADDR_W+1:0]   LOAD_ADDR,
   input  logic [WORD_W-1:0]   LOAD_DATA
);

   localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BLOCK_W-1:0]  data_q, data_d;
   logic [BLOCK_W-1:0]  blk_rdata;
   logic                busywait_c;

   inst_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .CLK        (CLK),
      .WRITE_EN   (LOAD_EN),
      .WRITE_ADDR (LOAD_ADDR),
      .WRITE_DATA (LOAD_DATA),
      .READ_ADDR  (addr_q),
      .READ_DATA  (blk_rdata)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Busywait is raised combinationally in the request cycle so the cache
   // sees a stall at the very first edge after it raises READ.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      busywait_c = 1'b0;
      case (state_q)
         IDLE: begin
            busywait_c = INST_MEM_READ;
            if (INST_MEM_READ) begin
               addr_d  = INST_MEM_ADDRESS;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            busywait_c = 1'b1;
            if (!INST_MEM_READ) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = blk_rdata;
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign INST_MEM_DATA     = data_q;
   assign INST_MEM_BUSYWAIT = busywait_c;

endmodule

// File: tb/tb_inst_block_memory.sv
// Self-checking bench: cache-style requester, random preload traffic and a
// timestamp-based reference model compared against the DUT every cycle.
module tb_inst_block_memory;

   localparam int unsigned LAT  = 5;
   localparam int unsigned AW   = 6;
   localparam int unsigned LW   = AW + 2;
   localparam int unsigned NBLK = 1 << AW;

   logic           CLK     = 1'b0;
   logic           RESET   = 1'b0;
   logic           rd      = 1'b0;
   logic [AW-1:0]  addr    = '0;
   logic           rd1     = 1'b0;
   logic [AW-1:0]  addr1   = '0;
   logic           ld_en   = 1'b0;
   logic [LW-1:0]  ld_addr = '0;
   logic [31:0]    ld_data = '0;
   logic [127:0]   data, data1;
   logic           bw, bw1;

   int total = 0;
   int bad   = 0;
   bit noise_en = 1'b0;

   always #5 CLK = ~CLK;

   inst_block_memory #(.LATENCY(LAT), .ADDR_W(AW)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .INST_MEM_READ     (rd),
      .INST_MEM_ADDRESS  (addr),
      .INST_MEM_DATA     (data),
      .INST_MEM_BUSYWAIT (bw),
      .LOAD_EN           (ld_en),
      .LOAD_ADDR         (ld_addr),
      .LOAD_DATA         (ld_data)
   );

   inst_block_memory #(.LATENCY(1), .ADDR_W(AW)) dut1 (
      .CLK               (CLK),
      .RESET             (RESET),
      .INST_MEM_READ     (rd1),
      .INST_MEM_ADDRESS  (addr1),
      .INST_MEM_DATA     (data1),
      .INST_MEM_BUSYWAIT (bw1),
      .LOAD_EN           (ld_en),
      .LOAD_ADDR         (ld_addr),
      .LOAD_DATA         (ld_data)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h at t=%0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: whole blocks as 128-bit values; a pending request is its
   // acceptance edge number and is answered LAT edges later unless READ drops.
   logic [127:0]  m_mem [NBLK];
   bit            m_active = 1'b0;
   int            m_tacc   = 0;
   int            m_resp   = -10;
   int            edge_n   = 0;
   logic [AW-1:0] m_addr   = '0;
   logic [127:0]  m_data   = '0;
   int unsigned   m_sh;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_active = 1'b0;
         m_data   = '0;
         m_resp   = -10;
      end else begin
         edge_n++;
         if (m_active && !rd) begin
            m_active = 1'b0;
         end else if (m_active && edge_n == m_tacc + int'(LAT)) begin
            m_data   = m_mem[m_addr];
            m_active = 1'b0;
            m_resp   = edge_n;
         end else if (!m_active && rd && m_resp != edge_n - 1) begin
            m_active = 1'b1;
            m_tacc   = edge_n;
            m_addr   = addr;
         end
         if (ld_en) begin
            m_sh = 32 * (3 - int'(ld_addr[1:0]));
            m_mem[ld_addr[LW-1:2]] = (m_mem[ld_addr[LW-1:2]] & ~(128'hFFFFFFFF << m_sh))
                                   | (128'(ld_data) << m_sh);
         end
      end
   end

   always @(negedge CLK) begin
      chk("data", data, m_data);
      chk("busywait", 128'(bw), 128'(m_active || (rd && m_resp != edge_n)));
   end

   initial forever begin
      @(posedge CLK); #2;
      if (noise_en) begin
         ld_en   = ($urandom_range(0, 2) == 0);
         ld_addr = LW'($urandom);
         ld_data = $urandom;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: still running at t=%0t, required finished", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK); #2;
      end
   endtask

   task automatic load_word(input logic [LW-1:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge CLK); #2;
      ld_en = 1'b0;
   endtask

   // Behaves like the cache: holds READ until it samples BUSYWAIT low.
   task automatic cache_read(input logic [AW-1:0] a, input int abort_at, input int load_at,
                             input logic [LW-1:0] la, input logic [31:0] ldv,
                             output logic [127:0] got, output int nbusy);
      bit done;
      done = 1'b0; got = '0; nbusy = 0;
      rd = 1'b1; addr = a;
      for (int c = 0; c < 4 * int'(LAT) + 16 && !done; c++) begin
         @(negedge CLK);
         if (!bw) begin
            got  = data;
            done = 1'b1;
         end else begin
            nbusy++;
         end
         @(posedge CLK); #2;
         if (nbusy >= 2 && !done) addr = AW'($urandom);
         if (load_at >= 0) begin
            ld_en = (nbusy == load_at) && !done; ld_addr = la; ld_data = ldv;
         end
         if (!done && nbusy == abort_at) done = 1'b1;
         if (done) rd = 1'b0;
      end
      if (load_at >= 0) ld_en = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL read_timeout: busywait still high after %0d cycles, required low", nbusy);
         rd = 1'b0;
      end
   endtask

   initial begin
      logic [127:0] got, tmp, blk3, blk4, blk3b;
      int nb;
      blk3  = 128'h11111111_22222222_33333333_44444444;
      blk4  = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
      blk3b = 128'h11111111_22222222_33333333_DEADBEEF;

      step(2);
      @(negedge CLK);
      chk("reset_data", data, 128'h0);
      chk("reset_busywait", 128'(bw), 128'h0);
      chk("reset_data_l1", data1, 128'h0);
      @(posedge CLK); #2;
      RESET = 1'b1;
      step(1);

      for (int i = 0; i < int'(NBLK) * 4; i++) load_word(LW'(i), $urandom);
      for (int w = 0; w < 4; w++) begin
         tmp = blk3 >> (32 * (3 - w));
         load_word(LW'(12 + w), tmp[31:0]);
         tmp = blk4 >> (32 * (3 - w));
         load_word(LW'(16 + w), tmp[31:0]);
      end

      // single read, then READ held past RESPOND to prove it lasts one cycle
      cache_read(AW'(3), -1, -1, '0, '0, got, nb);
      chk("t1_busy_edges", 128'(nb), 128'd6);
      chk("t1_data", got, blk3);
      rd = 1'b1; addr = AW'(3);
      @(negedge CLK);
      chk("t1_respond_one_cycle", 128'(bw), 128'h1);
      @(posedge CLK); #2;
      cache_read(AW'(3), -1, -1, '0, '0, got, nb);
      chk("t1_again_data", got, blk3);

      step(1);
      cache_read(AW'(4), -1, -1, '0, '0, got, nb);
      chk("t2_b2b_data", got, blk4);
      chk("t2_b2b_busy_edges", 128'(nb), 128'd6);

      // abort in the second BUSY cycle
      step(1);
      cache_read(AW'(5), 2, -1, '0, '0, got, nb);
      step(1);
      @(negedge CLK);
      chk("t3_abort_idle", 128'(bw), 128'h0);
      chk("t3_abort_data", data, blk4);
      @(posedge CLK); #2;
      step(int'(LAT) + 2);
      @(negedge CLK);
      chk("t3_no_respond", data, blk4);
      @(posedge CLK); #2;

      // load at the capture edge returns the old word, two edges earlier the new one
      cache_read(AW'(3), -1, int'(LAT), LW'(15), 32'hDEADBEEF, got, nb);
      chk("t4_same_edge", 128'(got[31:0]), 128'h44444444);
      step(1);
      load_word(LW'(15), 32'h44444444);
      cache_read(AW'(3), -1, 3, LW'(15), 32'hDEADBEEF, got, nb);
      chk("t4_earlier_edge", 128'(got[31:0]), 128'hDEADBEEF);
      step(1);

      // reset in the middle of BUSY, released with READ still high
      rd = 1'b1; addr = AW'(3);
      step(3);
      RESET = 1'b0;
      #1;
      chk("t5_async_data", data, 128'h0);
      @(posedge CLK); #2;
      RESET = 1'b1;
      cache_read(AW'(3), -1, -1, '0, '0, got, nb);
      chk("t5_restart_edges", 128'(nb), 128'd6);
      chk("t5_array_intact", got, blk3b);
      step(1);

      // LATENCY=1 instance: accept, one BUSY cycle, RESPOND
      rd1 = 1'b1; addr1 = AW'(4);
      @(negedge CLK);
      chk("l1_request", 128'(bw1), 128'h1);
      @(posedge CLK); #2;
      @(negedge CLK);
      chk("l1_busy", 128'(bw1), 128'h1);
      @(posedge CLK); #2;
      @(negedge CLK);
      chk("l1_respond_bw", 128'(bw1), 128'h0);
      chk("l1_data", data1, blk4);
      @(posedge CLK); #2;
      rd1 = 1'b0;
      @(negedge CLK);
      chk("l1_idle", 128'(bw1), 128'h0);
      @(posedge CLK); #2;

      // randomized traffic: reads, aborts, concurrent loads, occasional resets
      noise_en = 1'b1;
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 29) == 0) begin
            noise_en = 1'b0; ld_en = 1'b0;
            rd = ($urandom_range(0, 1) == 1); addr = AW'($urandom);
            RESET = 1'b0;
            step($urandom_range(1, 2));
            RESET = 1'b1;
            noise_en = 1'b1;
            if (rd) cache_read(addr, -1, -1, '0, '0, got, nb);
            else step(1);
         end else begin
            cache_read(AW'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, LAT)) : -1,
                       -1, '0, '0, got, nb);
            step($urandom_range(0, 3));
         end
      end
      noise_en = 1'b0; ld_en = 1'b0; rd = 1'b0;
      step(int'(LAT) + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
